// File: rtl/simd_pipeline_sequencer.sv
// Program sequencer for a four-stage SIMD pipeline: buffers a loaded program,
// issues it in order on start, tracks stage occupancy and signals completion.
module simd_pipeline_sequencer #(
    parameter int DEPTH = 64,
    parameter int IW    = 25,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load_valid,
    input  logic [IW-1:0] load_instr,
    output logic          load_ready,
    input  logic          start,
    input  logic          pause,
    output logic          busy,
    output logic          done,
    output logic          fetch_en,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] instr_out,
    output logic [3:0]    stage_valid,
    output logic          wb_commit,
    output logic [AW:0]   instr_count,
    output logic [AW:0]   commit_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_N   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PC  = AW'(1);

    state_t        state, state_next;
    logic [IW-1:0] mem [DEPTH];
    logic          load_fire;
    logic          start_fire;
    logic [AW:0]   n_eff;
    logic          run_go;
    logic          last_issue;
    logic          last_commit;

    assign load_fire   = load_valid && load_ready;
    assign start_fire  = (state == S_IDLE) && start && !clear;
    // Program length as it will be after a load accepted in the same cycle.
    assign n_eff       = instr_count + (load_fire ? ONE_N : '0);
    assign run_go      = start_fire && (n_eff != '0);
    assign last_issue  = fetch_en && ({1'b0, pc} == instr_count - ONE_N);
    assign wb_commit   = stage_valid[3];
    assign last_commit = wb_commit && (commit_count + ONE_N == instr_count);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_fire) state_next = (n_eff != '0) ? S_RUN : S_DONE;
            S_RUN:   if (last_issue) state_next = S_DRAIN;
            S_DRAIN: if (last_commit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        fetch_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  load_ready = !clear && (instr_count < DEPTH_N);
            S_RUN:   begin
                fetch_en = !pause;
                busy     = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            instr_out    <= '0;
            stage_valid  <= '0;
            instr_count  <= '0;
            commit_count <= '0;
        end else begin
            // The shift runs in every state so a pause only inserts a bubble.
            stage_valid <= {stage_valid[2:0], fetch_en};

            if (state == S_IDLE && clear) instr_count <= '0;
            else if (load_fire)           instr_count <= instr_count + ONE_N;

            if (run_go) begin
                pc <= '0;
            end else if (fetch_en) begin
                instr_out <= mem[pc];
                pc        <= pc + ONE_PC;
            end

            if (run_go)         commit_count <= '0;
            else if (wb_commit) commit_count <= commit_count + ONE_N;
        end
    end

    // NOTE: buffer storage has no reset; its contents are meaningless until reloaded.
    always_ff @(posedge clk) begin
        if (load_fire) mem[instr_count[AW-1:0]] <= load_instr;
    end

endmodule

// File: tb/tb_simd_pipeline_sequencer.sv
// Directed bench for simd_pipeline_sequencer: per-cycle vector tables for the
// basic and paused runs, hand sequences for reset, full buffer and corner cases.
module tb_simd_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        load_valid;
    logic [24:0] load_instr;
    logic        load_ready;
    logic        start;
    logic        pause;
    logic        busy;
    logic        done;
    logic        fetch_en;
    logic [5:0]  pc;
    logic [24:0] instr_out;
    logic [3:0]  stage_valid;
    logic        wb_commit;
    logic [6:0]  instr_count;
    logic [6:0]  commit_count;

    int total = 0;
    int bad   = 0;

    simd_pipeline_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_instr   (load_instr),
        .load_ready   (load_ready),
        .start        (start),
        .pause        (pause),
        .busy         (busy),
        .done         (done),
        .fetch_en     (fetch_en),
        .pc           (pc),
        .instr_out    (instr_out),
        .stage_valid  (stage_valid),
        .wb_commit    (wb_commit),
        .instr_count  (instr_count),
        .commit_count (commit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        pause;
        logic        exp_fetch;
        logic        exp_busy;
        logic        exp_done;
        logic [5:0]  exp_pc;
        logic [3:0]  exp_sv;
        logic [6:0]  exp_cc;
        logic [24:0] exp_instr;
    } vec_t;

    vec_t vec [23];

    function automatic logic [24:0] a_w(input int k);
        return 25'h00A0000 + 25'(k);
    endfunction
    function automatic logic [24:0] b_w(input int k);
        return 25'h00B0000 + 25'(k);
    endfunction
    function automatic logic [24:0] c_w(input int k);
        return 25'h00C0000 + 25'(k);
    endfunction
    function automatic logic [24:0] d_w(input int k);
        return 25'h1D00000 + 25'(k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [24:0] v);
        load_valid = 1'b1;
        load_instr = v;
        next();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next();
        clear = 1'b0;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start = vec[i].start;
            pause = vec[i].pause;
            #2;
            check($sformatf("row%0d fetch_en", i), 32'(fetch_en), 32'(vec[i].exp_fetch));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vec[i].exp_busy));
            check($sformatf("row%0d done", i), 32'(done), 32'(vec[i].exp_done));
            check($sformatf("row%0d pc", i), 32'(pc), 32'(vec[i].exp_pc));
            check($sformatf("row%0d stage_valid", i), 32'(stage_valid), 32'(vec[i].exp_sv));
            check($sformatf("row%0d wb_commit", i), 32'(wb_commit), 32'(vec[i].exp_sv[3]));
            check($sformatf("row%0d commit_count", i), 32'(commit_count), 32'(vec[i].exp_cc));
            check($sformatf("row%0d instr_out", i), 32'(instr_out), 32'(vec[i].exp_instr));
            next();
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " fetch_en"}, 32'(fetch_en), 32'd0);
        check({tag, " pc"}, 32'(pc), 32'd0);
        check({tag, " instr_out"}, 32'(instr_out), 32'd0);
        check({tag, " stage_valid"}, 32'(stage_valid), 32'd0);
        check({tag, " instr_count"}, 32'(instr_count), 32'd0);
        check({tag, " commit_count"}, 32'(commit_count), 32'd0);
    endtask

    initial begin
        // Basic run, N=3, start in row 0 (edge T closes row 0).
        //               st    pa    fe    bz    dn    pc    sv       cc    instr
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 4'b0000, 7'd0, 25'd0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 4'b0000, 7'd0, 25'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 4'b0001, 7'd0, a_w(0)};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 4'b0011, 7'd0, a_w(1)};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 4'b0111, 7'd0, a_w(2)};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 4'b1110, 7'd0, a_w(2)};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 4'b1100, 7'd1, a_w(2)};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 4'b1000, 7'd2, a_w(2)};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 4'b0000, 7'd3, a_w(2)};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 4'b0000, 7'd3, a_w(2)};
        // Paused run, N=4, pause held in RUN cycles 2 and 3.
        vec[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 4'b0000, 7'd3, a_w(2)};
        vec[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 4'b0000, 7'd0, a_w(2)};
        vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 4'b0001, 7'd0, b_w(0)};
        vec[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 4'b0010, 7'd0, b_w(0)};
        vec[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 4'b0100, 7'd0, b_w(0)};
        vec[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 4'b1001, 7'd0, b_w(1)};
        vec[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd3, 4'b0011, 7'd1, b_w(2)};
        vec[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 4'b0111, 7'd1, b_w(3)};
        vec[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 4'b1110, 7'd1, b_w(3)};
        vec[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 4'b1100, 7'd2, b_w(3)};
        vec[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 4'b1000, 7'd3, b_w(3)};
        vec[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 4'b0000, 7'd4, b_w(3)};
        vec[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, 4'b0000, 7'd4, b_w(3)};

        reset = 1'b1;
        clear = 1'b0;
        load_valid = 1'b0;
        load_instr = '0;
        start = 1'b0;
        pause = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;
        #2;
        check("por load_ready", 32'(load_ready), 32'd1);

        // Basic run, then an identical re-run of the retained program.
        next();
        for (int k = 0; k < 3; k++) begin
            load(a_w(k));
            #2;
            check($sformatf("basic load %0d count", k), 32'(instr_count), 32'(k + 1));
            next();
        end
        run_table(0, 9);

        start = 1'b1;
        next();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next();
            #2;
            check($sformatf("rerun instr_out %0d", k), 32'(instr_out), 32'(a_w(k)));
        end
        repeat (4) next();
        #2;
        check("rerun done", 32'(done), 32'd1);
        check("rerun commit_count", 32'(commit_count), 32'd3);
        next();

        // Paused run.
        do_clear();
        #2;
        check("clear instr_count", 32'(instr_count), 32'd0);
        next();
        for (int k = 0; k < 4; k++) load(b_w(k));
        run_table(10, 22);

        // Empty program: done one cycle after start, busy never rises.
        do_clear();
        start = 1'b1;
        #2;
        check("empty busy T", 32'(busy), 32'd0);
        next();
        start = 1'b0;
        #2;
        check("empty done T+1", 32'(done), 32'd1);
        check("empty busy T+1", 32'(busy), 32'd0);
        next();
        #2;
        check("empty done T+2", 32'(done), 32'd0);
        check("empty busy T+2", 32'(busy), 32'd0);
        next();

        // Load and start in the same cycle: the run covers the new instruction.
        load(c_w(0));
        load(c_w(1));
        load_valid = 1'b1;
        load_instr = c_w(2);
        start = 1'b1;
        next();
        load_valid = 1'b0;
        start = 1'b0;
        #2;
        check("ld+start instr_count", 32'(instr_count), 32'd3);
        check("ld+start busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            next();
            #2;
            check($sformatf("ld+start instr_out %0d", k), 32'(instr_out), 32'(c_w(k)));
        end
        repeat (4) next();
        #2;
        check("ld+start done", 32'(done), 32'd1);
        check("ld+start commit_count", 32'(commit_count), 32'd3);
        next();

        // Clear and start together: buffer empties, no run and no done.
        clear = 1'b1;
        start = 1'b1;
        #2;
        check("clr+start load_ready", 32'(load_ready), 32'd0);
        next();
        clear = 1'b0;
        start = 1'b0;
        #2;
        check("clr+start instr_count", 32'(instr_count), 32'd0);
        check("clr+start busy", 32'(busy), 32'd0);
        check("clr+start done", 32'(done), 32'd0);
        next();
        #2;
        check("clr+start busy+1", 32'(busy), 32'd0);
        check("clr+start done+1", 32'(done), 32'd0);
        next();

        // Fill the buffer with 65 back-to-back offers; the last is refused.
        for (int i = 0; i < 65; i++) begin
            load_valid = 1'b1;
            load_instr = d_w(i);
            #2;
            check($sformatf("full load_ready %0d", i), 32'(load_ready), (i < 64) ? 32'd1 : 32'd0);
            next();
        end
        load_valid = 1'b0;
        #2;
        check("full instr_count", 32'(instr_count), 32'd64);
        check("full load_ready", 32'(load_ready), 32'd0);
        start = 1'b1;
        next();
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            next();
            #2;
            check($sformatf("full instr_out %0d", k), 32'(instr_out), 32'(d_w(k)));
        end
        repeat (4) next();
        #2;
        check("full done", 32'(done), 32'd1);
        check("full commit_count", 32'(commit_count), 32'd64);
        next();

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        next();
        start = 1'b0;
        repeat (5) next();
        #2;
        check("midrun busy before reset", 32'(busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("midrun");
        next();
        reset = 1'b0;
        #2;
        check("post-reset load_ready", 32'(load_ready), 32'd1);
        check("post-reset busy", 32'(busy), 32'd0);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
